// File: rtl/synth_seq_pkg.sv
// Shared types and op-graph tables for the synthetic assay sequencer.
package synth_seq_pkg;

    localparam int unsigned NUM_OPS     = 10;
    localparam int unsigned NUM_CLASSES = 4;
    localparam int unsigned OP_IDX_W    = 4;
    localparam int unsigned CLS_W       = 2;

    // Operation classes; value doubles as the unit index
    typedef enum logic [CLS_W-1:0] {
        CLS_MIX  = 2'd0,
        CLS_HEAT = 2'd1,
        CLS_FILT = 2'd2,
        CLS_DET  = 2'd3
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Class of each op, element i = op i (MSB entry is op 9)
    localparam logic [NUM_OPS-1:0][CLS_W-1:0] OP_CLASS = {
        CLS_DET,  // 9 Detect_o10
        CLS_MIX,  // 8 m9
        CLS_FILT, // 7 Filter_o8
        CLS_MIX,  // 6 m7
        CLS_HEAT, // 5 Heat_o6
        CLS_DET,  // 4 Detect_o5
        CLS_FILT, // 3 Filter_o4
        CLS_HEAT, // 2 Heat_o3
        CLS_MIX,  // 1 Mix_o2
        CLS_MIX   // 0 Mix_o1
    };

    // Row i holds the ops that must be done before op i may start
    localparam logic [NUM_OPS-1:0][NUM_OPS-1:0] OP_DEPS = {
        10'b01_0000_0000, // 9 <- 8
        10'b00_1010_0000, // 8 <- 7, 5
        10'b00_0100_0000, // 7 <- 6
        10'b00_0001_0100, // 6 <- 4, 2
        10'b00_0000_1000, // 5 <- 3
        10'b00_0000_0010, // 4 <- 1
        10'b00_0000_0001, // 3 <- 0
        10'b00_0000_0000, // 2
        10'b00_0000_0000, // 1
        10'b00_0000_0000  // 0
    };

endpackage

// File: rtl/synth_unit_timer.sv
// Per-class actuator timer: holds the owning op and counts its active cycles.
module synth_unit_timer
    import synth_seq_pkg::*;
#(
    parameter int unsigned TW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [TW-1:0]       dur,
    input  logic [OP_IDX_W-1:0] op_sel,
    output logic                busy,
    output logic [OP_IDX_W-1:0] owner,
    output logic                expire_c
);

    logic [TW-1:0] count;

    // Load DUR-1 (zero duration behaves as one), count down, free on zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            busy  <= 1'b0;
            count <= '0;
            owner <= '0;
        end else if (load) begin
            busy  <= 1'b1;
            count <= (dur == '0) ? '0 : dur - TW'(1);
            owner <= op_sel;
        end else if (busy) begin
            if (count == '0) begin
                busy <= 1'b0;
            end else begin
                count <= count - TW'(1);
            end
        end
    end

    // Last active cycle of the current owner
    assign expire_c = busy && (count == '0);

endmodule

// File: rtl/synthetic_assay_sequencer.sv
// Scheduler for the 10-op synthetic assay graph with one shared unit per class.
// Optional runtime duration registers: define SYNTH_SEQ_CFG_EN.
module synthetic_assay_sequencer
    import synth_seq_pkg::*;
#(
    parameter int unsigned TW       = 8,
    parameter int unsigned MIX_DUR  = 4,
    parameter int unsigned HEAT_DUR = 8,
    parameter int unsigned FILT_DUR = 2,
    parameter int unsigned DET_DUR  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic [NUM_OPS-1:0]     op_active,
    output logic [NUM_CLASSES-1:0] unit_busy,
    output logic                   busy,
    output logic                   assay_done
`ifdef SYNTH_SEQ_CFG_EN
    ,
    input  logic                   cfg_we,
    input  logic [CLS_W-1:0]       cfg_class,
    input  logic [TW-1:0]          cfg_dur
`endif
);

    seq_state_e                           state;
    logic [NUM_OPS-1:0]                   started;
    logic [NUM_OPS-1:0]                   done_mask;
    logic [NUM_OPS-1:0]                   grant_c;
    logic [NUM_OPS-1:0]                   expire_ops_c;
    logic [NUM_CLASSES-1:0]               cls_grant_c;
    logic [NUM_CLASSES-1:0][OP_IDX_W-1:0] cls_idx_c;
    logic [NUM_CLASSES-1:0][OP_IDX_W-1:0] owner;
    logic [NUM_CLASSES-1:0]               expire_c;
    logic [NUM_CLASSES-1:0][TW-1:0]       dur_c;
    logic [CLS_W-1:0]                     cls_c;

`ifdef SYNTH_SEQ_CFG_EN
    logic [NUM_CLASSES-1:0][TW-1:0] dur_q;

    // Per-class duration registers, writable only outside a run
    always_ff @(posedge clk) begin
        if (rst) begin
            dur_q[CLS_MIX]  <= TW'(MIX_DUR);
            dur_q[CLS_HEAT] <= TW'(HEAT_DUR);
            dur_q[CLS_FILT] <= TW'(FILT_DUR);
            dur_q[CLS_DET]  <= TW'(DET_DUR);
        end else if (cfg_we && (state != ST_RUN)) begin
            dur_q[cfg_class] <= cfg_dur;
        end
    end

    assign dur_c = dur_q;
`else
    assign dur_c[CLS_MIX]  = TW'(MIX_DUR);
    assign dur_c[CLS_HEAT] = TW'(HEAT_DUR);
    assign dur_c[CLS_FILT] = TW'(FILT_DUR);
    assign dur_c[CLS_DET]  = TW'(DET_DUR);
`endif

    // Per class, grant the lowest-index op that is unstarted, unblocked and whose unit is free
    always_comb begin
        grant_c     = '0;
        cls_grant_c = '0;
        cls_idx_c   = '0;
        cls_c       = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            cls_c = OP_CLASS[i];
            if ((state == ST_RUN) && !started[i] &&
                ((OP_DEPS[i] & ~done_mask) == '0) &&
                !unit_busy[cls_c] && !cls_grant_c[cls_c]) begin
                grant_c[i]         = 1'b1;
                cls_grant_c[cls_c] = 1'b1;
                cls_idx_c[cls_c]   = OP_IDX_W'(i);
            end
        end
    end

    // One timer per class; its busy flag is the unit-occupied output
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_unit
        synth_unit_timer #(.TW(TW)) u_timer (
            .clk      (clk),
            .rst      (rst),
            .clear    (abort),
            .load     (cls_grant_c[k]),
            .dur      (dur_c[k]),
            .op_sel   (cls_idx_c[k]),
            .busy     (unit_busy[k]),
            .owner    (owner[k]),
            .expire_c (expire_c[k])
        );
    end

    // Map unit expiry back to the owning op
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_exp
        assign expire_ops_c[i] = expire_c[OP_CLASS[i]] &&
                                 (owner[OP_CLASS[i]] == OP_IDX_W'(i));
    end

    // Run-control FSM with op bookkeeping and registered status outputs
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            assay_done <= 1'b0;
            started    <= '0;
            done_mask  <= '0;
            op_active  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        assay_done <= 1'b0;
                        started    <= '0;
                        done_mask  <= '0;
                        op_active  <= '0;
                    end
                end
                ST_RUN: begin
                    op_active <= (op_active & ~expire_ops_c) | grant_c;
                    started   <= started | grant_c;
                    done_mask <= done_mask | expire_ops_c;
                    if (&done_mask) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        assay_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
